alu_bus_sequencer: RTL and testbench



---
 rtl/alu_bus_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_bus_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_bus_sequencer.sv
// Control-side initiator for the ALU: latches an operation, walks the ALU latch
// enables in a fixed order, arbitrates for the shared bus and captures the result.
module alu_bus_sequencer #(
  parameter int unsigned GNT_TIMEOUT = 15,
  parameter int unsigned SETTLE      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [15:0] ALU_In1,
  output logic [15:0] ALU_In2,
  output logic [2:0]  ALU_Sel,
  output logic        ALU_In1_En,
  output logic        ALU_In2_En,
  output logic        ALU_Out_En,
  output logic        BUS_Tri_En,
  output logic        bus_req,
  input  logic        bus_gnt,
  input  logic [15:0] BUS_In
);

  localparam int unsigned DW = 16;
  localparam int unsigned OW = 3;
  localparam int unsigned TW = 8;
  localparam int unsigned SW = 4;
  localparam logic [OW-1:0] OP_RSVD = OW'(7);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_REQ, S_DRIVE, S_DONE
  } state_t;

  state_t        state, state_d;
  logic [SW-1:0] settle_cnt, settle_cnt_d;
  logic [TW-1:0] tmo_cnt, tmo_cnt_d;
  logic          err_d, accept, capture;
  logic          busy_d, done_d, in1_en_d, in2_en_d, out_en_d, tri_en_d, bus_req_d;

  // Next-state logic; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_d      = state;
    settle_cnt_d = settle_cnt;
    tmo_cnt_d    = tmo_cnt;
    err_d        = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_RSVD) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_LOAD_A;
          end
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: begin
        state_d      = S_EXEC;
        settle_cnt_d = SW'(SETTLE - 1);
      end
      S_EXEC: begin
        if (settle_cnt == '0) begin
          state_d   = S_REQ;
          tmo_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt - SW'(1);
        end
      end
      S_REQ: begin
        // A grant in the final allowed cycle still beats the timeout
        if (bus_gnt) begin
          state_d = S_DRIVE;
        end else if (tmo_cnt == TW'(GNT_TIMEOUT)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt + TW'(1);
        end
      end
      S_DRIVE: begin
        capture = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    in1_en_d  = (state_d == S_LOAD_A);
    in2_en_d  = (state_d == S_LOAD_B);
    out_en_d  = (state_d == S_EXEC);
    tri_en_d  = (state_d == S_DRIVE);
    bus_req_d = (state_d == S_REQ) || (state_d == S_DRIVE);
  end

  // State, counters and every output; async reset releases the bus immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      result     <= '0;
      ALU_In1    <= '0;
      ALU_In2    <= '0;
      ALU_Sel    <= '0;
      ALU_In1_En <= 1'b0;
      ALU_In2_En <= 1'b0;
      ALU_Out_En <= 1'b0;
      BUS_Tri_En <= 1'b0;
      bus_req    <= 1'b0;
    end else begin
      state      <= state_d;
      settle_cnt <= settle_cnt_d;
      tmo_cnt    <= tmo_cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      ALU_In1_En <= in1_en_d;
      ALU_In2_En <= in2_en_d;
      ALU_Out_En <= out_en_d;
      BUS_Tri_En <= tri_en_d;
      bus_req    <= bus_req_d;
      if (accept) begin
        ALU_In1 <= DW'(opa);
        ALU_In2 <= DW'(opb);
        ALU_Sel <= op;
      end
      if (capture) begin
        result <= BUS_In;
      end
    end
  end

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Bench for alu_bus_sequencer: behavioural ALU and arbiter, table of operations,
// scoreboard on done, plus reset-during-DRIVE sequence.
module tb_alu_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] opa, opb;
  logic        busy, done, err;
  logic [15:0] result, ALU_In1, ALU_In2;
  logic [2:0]  ALU_Sel;
  logic        ALU_In1_En, ALU_In2_En, ALU_Out_En, BUS_Tri_En, bus_req, bus_gnt;
  logic [15:0] BUS_In;

  alu_bus_sequencer #(.GNT_TIMEOUT(15), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .err(err), .result(result),
    .ALU_In1(ALU_In1), .ALU_In2(ALU_In2), .ALU_Sel(ALU_Sel),
    .ALU_In1_En(ALU_In1_En), .ALU_In2_En(ALU_In2_En), .ALU_Out_En(ALU_Out_En),
    .BUS_Tri_En(BUS_Tri_En), .bus_req(bus_req), .bus_gnt(bus_gnt), .BUS_In(BUS_In)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int overlap_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Behavioural ALU with latches driven by the DUT enables
  function automatic logic [15:0] alu_f(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return 16'h0000;
    endcase
  endfunction

  logic [15:0] a_lat = '0, b_lat = '0, out_lat = '0;
  always_ff @(posedge clk) begin
    if (ALU_In1_En) a_lat <= ALU_In1;
    if (ALU_In2_En) b_lat <= ALU_In2;
    if (ALU_Out_En) out_lat <= alu_f(ALU_Sel, a_lat, b_lat);
  end
  assign BUS_In = BUS_Tri_En ? out_lat : 16'hDEAD;

  // Arbiter: grants once bus_req has been high for gnt_after cycles
  int req_cnt = 0;
  int gnt_after = 0;
  always_ff @(posedge clk) req_cnt <= bus_req ? req_cnt + 1 : 0;
  assign bus_gnt = (req_cnt >= gnt_after);

  typedef struct {
    logic [15:0] res;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(1), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("result", 32'(result), 32'(mon_e.res));
        chk("err", 32'(err), 32'(mon_e.err));
      end
    end
  end

  always @(negedge clk)
    if ((int'(ALU_In1_En) + int'(ALU_In2_En) + int'(ALU_Out_En) + int'(BUS_Tri_En)) > 1)
      overlap_cnt++;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b, res;
    logic        err;
    int          gnt_after, lat, n_req, n_drv;
    logic        poke;
  } vec_t;

  vec_t vecs[9];
  logic [15:0] last_a = '0, last_b = '0;
  logic [2:0]  last_sel = '0;

  task automatic run_op(input vec_t v);
    int n = 0, c_in1 = 0, c_in2 = 0, c_out = 0, c_req = 0, c_drv = 0;
    bit found = 0, mid = 0;
    exp_t e;
    int n_alu;
    @(negedge clk);
    gnt_after = v.gnt_after;
    start = 1'b1; op = v.op; opa = v.a; opb = v.b;
    e.res = v.res; e.err = v.err;
    sb.push_back(e);
    if (v.op != 3'd7) begin last_a = v.a; last_b = v.b; last_sel = v.op; end
    n_alu = (v.op != 3'd7) ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0;
    while (!found && n <= 200) begin
      if (mid) begin start = 1'b0; mid = 0; end
      c_in1 += int'(ALU_In1_En); c_in2 += int'(ALU_In2_En); c_out += int'(ALU_Out_En);
      c_req += int'(bus_req);    c_drv += int'(BUS_Tri_En);
      if (done) found = 1;
      else begin
        if (v.poke && n == 2) begin start = 1'b1; op = 3'd0; opa = 16'hFFFF; mid = 1; end
        @(posedge clk); #1;
        n++;
      end
    end
    chk("done_seen", 32'(found), 32'(1));
    chk("latency", 32'(n), 32'(v.lat));
    chk("in1_en_cycles", 32'(c_in1), 32'(n_alu));
    chk("in2_en_cycles", 32'(c_in2), 32'(n_alu));
    chk("out_en_cycles", 32'(c_out), 32'(n_alu));
    chk("bus_req_cycles", 32'(c_req), 32'(v.n_req));
    chk("tri_en_cycles", 32'(c_drv), 32'(v.n_drv));
    chk("alu_in1_hold", 32'(ALU_In1), 32'(last_a));
    chk("alu_in2_hold", 32'(ALU_In2), 32'(last_b));
    chk("alu_sel_hold", 32'(ALU_Sel), 32'(last_sel));
    // start raised in the DONE cycle must not be queued
    if (v.poke) begin start = 1'b1; op = 3'd0; end
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_after_done", 32'(busy), 32'(0));
  endtask

  initial begin
    int guard;
    bit seen;
    vec_t fresh;
    rst = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0;

    //         op     a         b         res       err gnt  lat req drv poke
    vecs[0] = '{3'd0, 16'h004C, 16'h002A, 16'h0076, 0,  0,   5,  2,  1,  0};
    vecs[1] = '{3'd1, 16'h004C, 16'h002A, 16'h0022, 0,  0,   5,  2,  1,  1};
    vecs[2] = '{3'd2, 16'h004C, 16'h002A, 16'h0008, 0,  0,   5,  2,  1,  1};
    vecs[3] = '{3'd4, 16'h1234, 16'h00FF, 16'h12CB, 0,  0,   5,  2,  1,  0};
    vecs[4] = '{3'd7, 16'hAAAA, 16'h5555, 16'h12CB, 1,  0,   0,  0,  0,  0};
    vecs[5] = '{3'd0, 16'h1000, 16'h0234, 16'h1234, 0,  6,   11, 8,  1,  0};
    vecs[6] = '{3'd1, 16'h0F00, 16'h0001, 16'h1234, 1,  1000, 19, 16, 0,  0};
    vecs[7] = '{3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 0,  14,  19, 16, 1,  0};
    vecs[8] = '{3'd0, 16'hFFFF, 16'h0002, 16'h0001, 0,  15,  20, 17, 1,  0};

    #12;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_alu_in1", 32'(ALU_In1), 32'(0));
    chk("rst_bus_req", 32'(bus_req), 32'(0));
    chk("rst_tri_en", 32'(BUS_Tri_En), 32'(0));
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Reset asserted mid-cycle while the ALU is driving the bus
    @(negedge clk);
    gnt_after = 0; start = 1'b1; op = 3'd0; opa = 16'h0101; opb = 16'h0202;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!BUS_Tri_En && guard < 50) begin @(posedge clk); #1; guard++; end
    chk("reached_drive", 32'(BUS_Tri_En), 32'(1));
    #2; rst = 1'b0; #1;
    chk("arst_tri_en", 32'(BUS_Tri_En), 32'(0));
    chk("arst_bus_req", 32'(bus_req), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_result", 32'(result), 32'(0));
    chk("arst_alu_sel", 32'(ALU_Sel), 32'(0));
    last_a = '0; last_b = '0; last_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (4) begin @(negedge clk); seen |= done; end
    chk("no_done_after_reset", 32'(seen), 32'(0));

    fresh = '{3'd0, 16'h004C, 16'h002A, 16'h0076, 0, 0, 5, 2, 1, 0};
    run_op(fresh);

    repeat (3) @(negedge clk);
    chk("enable_overlap", 32'(overlap_cnt), 32'(0));
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
